dice_cgra_tid_dispatcher: RTL

DICE_CGRA_TID_DISPATCHER -- requirements
Module: dice_cgra_tid_dispatcher

---
 rtl/dice_cgra_pkg.sv | 15 +
 rtl/dice_cgra_drain_timer.sv | 43 ++++
 rtl/dice_cgra_tid_dispatcher.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dice_cgra_pkg.sv
// Shared types for the DICE CGRA thread-ID dispatcher.
// Holds the dispatcher FSM state encoding and the perf counter width.
package dice_cgra_pkg;

    // Dispatcher FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } disp_state_e;

    localparam int unsigned PERF_W = 32;

endpackage

// File: rtl/dice_cgra_drain_timer.sv
// Drain down-counter: loaded with the pipeline drain length, counts down
// while enabled and flags expiry in the last drain cycle.
module dice_cgra_drain_timer #(
    parameter int unsigned DRN_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [DRN_W-1:0] load_val,
    input  logic             count,
    output logic             expire
);

    logic [DRN_W-1:0] cnt_q, cnt_d;

    // Next count: clear beats load, load beats decrement
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (count && (cnt_q != '0)) begin
            cnt_d = cnt_q - DRN_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry marks the final counting cycle so the FSM leaves DRAIN on time
    always_comb begin
        expire = count && (cnt_q == DRN_W'(1));
    end

endmodule

// File: rtl/dice_cgra_tid_dispatcher.sv
// DICE CGRA thread-ID dispatcher: accepts a block launch, issues thread IDs
// 0..num-1 under back-pressure, waits out the pipeline drain, then pulses done.
// Optional feature: define DICE_DISP_PERF_CNT_EN to add the 32-bit
// perf_stall_cycles output counting stalled ISSUE cycles.
module dice_cgra_tid_dispatcher
    import dice_cgra_pkg::*;
#(
    parameter int unsigned NUM_TID   = 512,
    parameter int unsigned MAX_DRAIN = 64,
    localparam int unsigned TID_W    = $clog2(NUM_TID + 1),
    localparam int unsigned DRN_W    = $clog2(MAX_DRAIN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [TID_W-1:0] start_num_tid,
    input  logic [DRN_W-1:0] start_drain,
    input  logic             disp_stall,
    output logic [TID_W-1:0] disp_tid,
    output logic             disp_valid,
    output logic             busy,
    output logic             done
`ifdef DICE_DISP_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cycles
`endif
);

    disp_state_e      state_q, state_d;
    logic [TID_W-1:0] tid_cnt_q, tid_cnt_d;
    logic [TID_W-1:0] num_q, num_d;
    logic [DRN_W-1:0] drain_q, drain_d;
    logic [TID_W-1:0] num_clamped;
    logic             accept;
    logic             tmr_load;
    logic             tmr_count;
    logic             tmr_expire;

    // Handshake and issue outputs; clr suppresses issue and done in its cycle
    always_comb begin
        start_ready = (state_q == IDLE) && !clr;
        accept      = start_valid && start_ready;
        disp_valid  = (state_q == ISSUE) && !disp_stall && !clr;
        disp_tid    = tid_cnt_q;
        busy        = (state_q != IDLE);
        done        = (state_q == DONE) && !clr;
        num_clamped = (start_num_tid > TID_W'(NUM_TID)) ? TID_W'(NUM_TID) : start_num_tid;
    end

    // FSM and issue-counter next state
    always_comb begin
        state_d   = state_q;
        tid_cnt_d = tid_cnt_q;
        num_d     = num_q;
        drain_d   = drain_q;
        tmr_load  = 1'b0;
        tmr_count = 1'b0;
        if (clr) begin
            state_d   = IDLE;
            tid_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        num_d     = num_clamped;
                        drain_d   = start_drain;
                        tid_cnt_d = '0;
                        state_d   = (num_clamped == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (disp_valid) begin
                        tid_cnt_d = tid_cnt_q + TID_W'(1);
                        // Last TID: leave ISSUE on the following edge
                        if (tid_cnt_q == num_q - TID_W'(1)) begin
                            if (drain_q != '0) begin
                                state_d  = DRAIN;
                                tmr_load = 1'b1;
                            end else begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                DRAIN: begin
                    tmr_count = 1'b1;
                    if (tmr_expire) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tid_cnt_q <= '0;
            num_q     <= '0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            tid_cnt_q <= tid_cnt_d;
            num_q     <= num_d;
            drain_q   <= drain_d;
        end
    end

    dice_cgra_drain_timer #(
        .DRN_W (DRN_W)
    ) u_drain_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (tmr_load),
        .load_val (drain_q),
        .count    (tmr_count),
        .expire   (tmr_expire)
    );

`ifdef DICE_DISP_PERF_CNT_EN
    logic [PERF_W-1:0] perf_cnt_q, perf_cnt_d;

    // Stalled-ISSUE cycle counter, saturating, restarted by clr and each launch
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (clr || accept) begin
            perf_cnt_d = '0;
        end else if ((state_q == ISSUE) && disp_stall && !(&perf_cnt_q)) begin
            perf_cnt_d = perf_cnt_q + PERF_W'(1);
        end
    end

    // Perf counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign perf_stall_cycles = perf_cnt_q;
`endif

endmodule
